// File: rtl/be8_debug_host_if.sv
`default_nettype none
// ============================================================================
// Module   : be8_debug_host_if
// Brief    : Command, response and core debug-port signals of be8_debug_host.
// Revision : 1.0 - initial release
// ============================================================================
interface be8_debug_host_if #(
  parameter int ADDR_W = 4
);
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [2:0]        CMD_OP;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [7:0]        CMD_DATA;
  logic              RSP_VALID;
  logic              RSP_ERR;
  logic [7:0]        RDATA;
  logic              DEBUG_REQUEST;
  logic              DEBUG_ACK;
  logic [7:0]        DEBUG_DATA;
  logic              D_CLR, D_HLT, D_CE, D_SU, D_RI;
  logic              D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn, D_DOn;
  logic              D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn;
  logic [7:0]        BUS;

  modport master (
    input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, DEBUG_ACK, BUS,
    output CMD_READY, RSP_VALID, RSP_ERR, RDATA, DEBUG_REQUEST, DEBUG_DATA,
    output D_CLR, D_HLT, D_CE, D_SU, D_RI,
    output D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn, D_DOn,
    output D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn
  );

  modport slave (
    output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, DEBUG_ACK, BUS,
    input  CMD_READY, RSP_VALID, RSP_ERR, RDATA, DEBUG_REQUEST, DEBUG_DATA,
    input  D_CLR, D_HLT, D_CE, D_SU, D_RI,
    input  D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn, D_DOn,
    input  D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn
  );
endinterface
`default_nettype wire

// File: rtl/be8_debug_host.sv
`default_nettype none
// ============================================================================
// Module   : be8_debug_host
// Brief    : Debug-port initiator turning host commands into halt/step/release
//            transactions on the be8 core's debug inputs.
// Revision : 1.0 - initial release
// ============================================================================
module be8_debug_host #(
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  be8_debug_host_if.master dbg
);
  localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_MEM_WRITE = 3'd1;
  localparam logic [2:0] OP_MEM_READ  = 3'd2;
  localparam logic [2:0] OP_REG_READ  = 3'd3;
  localparam logic [2:0] OP_REG_WRITE = 3'd4;
  localparam logic [2:0] OP_CLEAR     = 3'd5;

  // Bit positions inside the active-low override vector
  localparam int L_AIN = 14, L_BIN = 13, L_OIN = 12, L_IIN = 11, L_JN  = 10;
  localparam int L_FIN = 9,  L_MIN = 8,  L_DON = 7,  L_AON = 6,  L_BON = 5;
  localparam int L_ION = 4,  L_CON = 3,  L_EON = 2,  L_RON = 1,  L_NON = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_STEP1 = 3'd2,
    S_STEP2 = 3'd3,
    S_REL   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state, nxt;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;
  logic [CNT_W-1:0]  cnt;
  logic              accept, timeout, two_step, nxt_err;
  logic [1:0]        sel;
  logic [4:0]        hi_d, hi_q;   // CLR HLT CE SU RI
  logic [14:0]       lo_d, lo_q;
  logic [7:0]        dd_d, dd_q;
  logic              req_q, ready_q, rsp_v_q, rsp_e_q;
  logic [7:0]        rdata_q;

  function automatic logic core_op(input logic [2:0] o);
    return (o != OP_NOP) && !(o[2] && o[1]);
  endfunction

  assign sel      = addr[1:0];
  assign accept   = dbg.CMD_VALID && ready_q;
  assign timeout  = (cnt == CNT_LAST);
  assign two_step = (op == OP_MEM_WRITE) || (op == OP_MEM_READ);

  always_comb begin
    nxt     = state;
    nxt_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (core_op(dbg.CMD_OP)) begin
            nxt = S_REQ;
          end else begin
            nxt     = S_DONE;
            nxt_err = dbg.CMD_OP[2] && dbg.CMD_OP[1];
          end
        end
      end
      S_REQ: begin
        if (dbg.DEBUG_ACK) begin
          nxt = S_STEP1;
        end else if (timeout) begin
          nxt     = S_DONE;
          nxt_err = 1'b1;
        end
      end
      S_STEP1: nxt = two_step ? S_STEP2 : S_REL;
      S_STEP2: nxt = S_REL;
      S_REL: begin
        if (!dbg.DEBUG_ACK) begin
          nxt = S_DONE;
        end else if (timeout) begin
          nxt     = S_DONE;
          nxt_err = 1'b1;
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Decode of the upcoming state, so every port leaves a flop
  always_comb begin
    hi_d = '0;
    lo_d = '1;
    dd_d = '0;
    if (nxt == S_STEP1) begin
      case (op)
        OP_MEM_WRITE, OP_MEM_READ: begin
          dd_d        = 8'(addr);
          lo_d[L_DON] = 1'b0;
          lo_d[L_MIN] = 1'b0;
        end
        OP_REG_READ: begin
          case (sel)
            2'd0:    lo_d[L_AON] = 1'b0;
            2'd1:    lo_d[L_BON] = 1'b0;
            2'd2:    lo_d[L_ION] = 1'b0;
            default: lo_d[L_CON] = 1'b0;
          endcase
        end
        OP_REG_WRITE: begin
          dd_d        = data;
          lo_d[L_DON] = 1'b0;
          case (sel)
            2'd0:    lo_d[L_AIN] = 1'b0;
            2'd1:    lo_d[L_BIN] = 1'b0;
            2'd2:    lo_d[L_OIN] = 1'b0;
            default: lo_d[L_JN]  = 1'b0;
          endcase
        end
        OP_CLEAR: hi_d[4] = 1'b1;
        default: ;
      endcase
    end else if (nxt == S_STEP2) begin
      if (op == OP_MEM_WRITE) begin
        dd_d        = data;
        lo_d[L_DON] = 1'b0;
        hi_d[0]     = 1'b1;
      end else begin
        lo_d[L_RON] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      op      <= OP_NOP;
      addr    <= '0;
      data    <= '0;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '1;
      dd_q    <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b1;
      rsp_v_q <= 1'b0;
      rsp_e_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op   <= dbg.CMD_OP;
        addr <= dbg.CMD_ADDR;
        data <= dbg.CMD_DATA;
      end
      if (nxt != state) begin
        cnt <= '0;
      end else if (state == S_REQ || state == S_REL) begin
        cnt <= cnt + 1'b1;
      end
      if ((state == S_STEP1 && op == OP_REG_READ) ||
          (state == S_STEP2 && op == OP_MEM_READ)) begin
        rdata_q <= dbg.BUS;
      end
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dd_q    <= dd_d;
      req_q   <= (nxt == S_REQ) || (nxt == S_STEP1) || (nxt == S_STEP2);
      ready_q <= (nxt == S_IDLE);
      rsp_v_q <= (nxt == S_DONE);
      rsp_e_q <= (nxt == S_DONE) && nxt_err;
    end
  end

  assign dbg.CMD_READY     = ready_q;
  assign dbg.RSP_VALID     = rsp_v_q;
  assign dbg.RSP_ERR       = rsp_e_q;
  assign dbg.RDATA         = rdata_q;
  assign dbg.DEBUG_REQUEST = req_q;
  assign dbg.DEBUG_DATA    = dd_q;
  assign {dbg.D_CLR, dbg.D_HLT, dbg.D_CE, dbg.D_SU, dbg.D_RI} = hi_q;
  assign dbg.D_AIn = lo_q[L_AIN];
  assign dbg.D_BIn = lo_q[L_BIN];
  assign dbg.D_OIn = lo_q[L_OIN];
  assign dbg.D_IIn = lo_q[L_IIN];
  assign dbg.D_Jn  = lo_q[L_JN];
  assign dbg.D_FIn = lo_q[L_FIN];
  assign dbg.D_MIn = lo_q[L_MIN];
  assign dbg.D_DOn = lo_q[L_DON];
  assign dbg.D_AOn = lo_q[L_AON];
  assign dbg.D_BOn = lo_q[L_BON];
  assign dbg.D_IOn = lo_q[L_ION];
  assign dbg.D_COn = lo_q[L_CON];
  assign dbg.D_EOn = lo_q[L_EON];
  assign dbg.D_ROn = lo_q[L_RON];
  assign dbg.D_NOn = lo_q[L_NON];
endmodule
`default_nettype wire

// File: tb/tb_be8_debug_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_be8_debug_host
// Brief    : Directed bench for be8_debug_host with a small core/RAM responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_be8_debug_host;
  localparam logic [19:0] IDLE_D = 20'h07FFF;
  localparam logic [19:0] M_CLR  = 20'h80000;
  localparam logic [19:0] M_RI   = 20'h08000;
  localparam logic [19:0] M_AIN  = 20'h04000;
  localparam logic [19:0] M_JN   = 20'h00400;
  localparam logic [19:0] M_MIN  = 20'h00100;
  localparam logic [19:0] M_DON  = 20'h00080;
  localparam logic [19:0] M_AON  = 20'h00040;
  localparam logic [19:0] M_CON  = 20'h00008;
  localparam logic [19:0] M_RON  = 20'h00002;
  localparam logic [19:0] MA_STEP = IDLE_D & ~(M_MIN | M_DON);

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  be8_debug_host_if #(.ADDR_W(4)) dbg ();

  be8_debug_host #(.ADDR_W(4), .ACK_TIMEOUT(64)) dut (
    .CLK   (clk),
    .RESET (rst),
    .dbg   (dbg.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core responder: acks one cycle after seeing DEBUG_REQUEST change
  logic [7:0] ram [16];
  logic [3:0] mar;
  logic [7:0] reg_a, reg_pc, model_bus;
  logic       ack_q;
  bit         ack_en;

  always @(posedge clk) begin
    if (rst) ack_q <= 1'b0;
    else if (ack_en) ack_q <= dbg.DEBUG_REQUEST;
    if (!dbg.D_MIn) mar <= model_bus[3:0];
    if (dbg.D_RI) ram[mar] <= model_bus;
    if (!dbg.D_AIn) reg_a <= model_bus;
    if (!dbg.D_Jn) reg_pc <= model_bus;
  end

  assign model_bus = !dbg.D_DOn ? dbg.DEBUG_DATA :
                     !dbg.D_ROn ? ram[mar]       :
                     !dbg.D_AOn ? reg_a          :
                     !dbg.D_COn ? reg_pc         : 8'h00;
  assign dbg.BUS       = model_bus;
  assign dbg.DEBUG_ACK = ack_q;

  function automatic logic [19:0] dvec();
    return {dbg.D_CLR, dbg.D_HLT, dbg.D_CE, dbg.D_SU, dbg.D_RI,
            dbg.D_AIn, dbg.D_BIn, dbg.D_OIn, dbg.D_IIn, dbg.D_Jn, dbg.D_FIn,
            dbg.D_MIn, dbg.D_DOn, dbg.D_AOn, dbg.D_BOn, dbg.D_IOn, dbg.D_COn,
            dbg.D_EOn, dbg.D_ROn, dbg.D_NOn};
  endfunction

  // Presents a command at a negedge; returns 1 time unit after the accept edge
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    dbg.CMD_VALID = 1'b1;
    dbg.CMD_OP    = op;
    dbg.CMD_ADDR  = a;
    dbg.CMD_DATA  = d;
    @(posedge clk);
    #1;
    dbg.CMD_VALID = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dbg.CMD_READY, dbg.RSP_VALID, dbg.RSP_ERR, dbg.DEBUG_REQUEST} !== 4'b1000 ||
        dbg.RDATA !== 8'h00 || dbg.DEBUG_DATA !== 8'h00 || dvec() !== IDLE_D) begin
      failures++;
      $display("FAIL reset got rdy/rv/re/req=%b%b%b%b rdata=%h dd=%h d=%h exp 1000 00 00 %h",
               dbg.CMD_READY, dbg.RSP_VALID, dbg.RSP_ERR, dbg.DEBUG_REQUEST,
               dbg.RDATA, dbg.DEBUG_DATA, dvec(), IDLE_D);
    end
    rst = 1'b0;
  endtask

  task automatic test_mem_write();
    issue(3'd1, 4'h5, 8'hA7);
    @(negedge clk);  // E0
    checks++;
    if ({dbg.DEBUG_REQUEST, dbg.CMD_READY, dbg.RSP_VALID} !== 3'b100) begin
      failures++;
      $display("FAIL mw_req got req/rdy/rv=%b%b%b exp 100", dbg.DEBUG_REQUEST, dbg.CMD_READY, dbg.RSP_VALID);
    end
    repeat (2) @(negedge clk);  // E2
    checks++;
    if (dvec() !== MA_STEP || dbg.DEBUG_DATA !== 8'h05 || dbg.DEBUG_REQUEST !== 1'b1) begin
      failures++;
      $display("FAIL mw_step1 got d=%h dd=%h req=%b exp d=%h dd=05 req=1", dvec(), dbg.DEBUG_DATA, dbg.DEBUG_REQUEST, MA_STEP);
    end
    @(negedge clk);  // E3
    checks++;
    if (dvec() !== ((IDLE_D & ~M_DON) | M_RI) || dbg.DEBUG_DATA !== 8'hA7 || dbg.DEBUG_REQUEST !== 1'b1) begin
      failures++;
      $display("FAIL mw_step2 got d=%h dd=%h req=%b exp d=%h dd=a7 req=1", dvec(), dbg.DEBUG_DATA, dbg.DEBUG_REQUEST, (IDLE_D & ~M_DON) | M_RI);
    end
    @(negedge clk);  // E4
    checks++;
    if (dbg.DEBUG_REQUEST !== 1'b0 || dvec() !== IDLE_D) begin
      failures++;
      $display("FAIL mw_rel got req=%b d=%h exp req=0 d=%h", dbg.DEBUG_REQUEST, dvec(), IDLE_D);
    end
    @(negedge clk);  // E5
    checks++;
    if (dbg.RSP_VALID !== 1'b0) begin
      failures++;
      $display("FAIL mw_early_rsp got rv=%b exp 0", dbg.RSP_VALID);
    end
    @(negedge clk);  // E6
    checks++;
    if ({dbg.RSP_VALID, dbg.RSP_ERR, dbg.CMD_READY} !== 3'b100) begin
      failures++;
      $display("FAIL mw_rsp got rv/re/rdy=%b%b%b exp 100", dbg.RSP_VALID, dbg.RSP_ERR, dbg.CMD_READY);
    end
    @(negedge clk);  // E7
    checks++;
    if ({dbg.RSP_VALID, dbg.RSP_ERR, dbg.CMD_READY} !== 3'b001 || ram[5] !== 8'hA7) begin
      failures++;
      $display("FAIL mw_after got rv/re/rdy=%b%b%b ram5=%h exp 001 a7", dbg.RSP_VALID, dbg.RSP_ERR, dbg.CMD_READY, ram[5]);
    end
  endtask

  task automatic test_mem_read();
    issue(3'd2, 4'h5, 8'h00);
    repeat (3) @(negedge clk);  // E2
    checks++;
    if (dvec() !== MA_STEP || dbg.DEBUG_DATA !== 8'h05) begin
      failures++;
      $display("FAIL mr_step1 got d=%h dd=%h exp d=%h dd=05", dvec(), dbg.DEBUG_DATA, MA_STEP);
    end
    @(negedge clk);  // E3
    checks++;
    if (dvec() !== (IDLE_D & ~M_RON) || dbg.RDATA !== 8'h00) begin
      failures++;
      $display("FAIL mr_step2 got d=%h rdata=%h exp d=%h rdata=00", dvec(), dbg.RDATA, IDLE_D & ~M_RON);
    end
    @(negedge clk);  // E4
    checks++;
    if (dbg.RDATA !== 8'hA7 || dbg.DEBUG_REQUEST !== 1'b0) begin
      failures++;
      $display("FAIL mr_rdata got rdata=%h req=%b exp a7 0", dbg.RDATA, dbg.DEBUG_REQUEST);
    end
    repeat (2) @(negedge clk);  // E6
    checks++;
    if ({dbg.RSP_VALID, dbg.RSP_ERR} !== 2'b10) begin
      failures++;
      $display("FAIL mr_rsp got rv/re=%b%b exp 10", dbg.RSP_VALID, dbg.RSP_ERR);
    end
  endtask

  task automatic test_reg_access();
    logic [1:0]  sel;
    logic [7:0]  val;
    logic [19:0] wr_d, rd_d;
    for (int k = 0; k < 2; k++) begin
      sel  = (k == 0) ? 2'd0 : 2'd3;
      val  = (k == 0) ? 8'h3C : 8'h42;
      wr_d = (k == 0) ? (IDLE_D & ~(M_AIN | M_DON)) : (IDLE_D & ~(M_JN | M_DON));
      rd_d = (k == 0) ? (IDLE_D & ~M_AON) : (IDLE_D & ~M_CON);
      issue(3'd4, {2'b00, sel}, val);
      repeat (3) @(negedge clk);  // E2
      checks++;
      if (dvec() !== wr_d || dbg.DEBUG_DATA !== val) begin
        failures++;
        $display("FAIL rw_step sel=%0d got d=%h dd=%h exp d=%h dd=%h", sel, dvec(), dbg.DEBUG_DATA, wr_d, val);
      end
      @(negedge clk);  // E3
      checks++;
      if (dvec() !== IDLE_D || dbg.DEBUG_REQUEST !== 1'b0) begin
        failures++;
        $display("FAIL rw_rel sel=%0d got d=%h req=%b exp d=%h req=0", sel, dvec(), dbg.DEBUG_REQUEST, IDLE_D);
      end
      repeat (2) @(negedge clk);  // E5
      checks++;
      if ({dbg.RSP_VALID, dbg.RSP_ERR} !== 2'b10) begin
        failures++;
        $display("FAIL rw_rsp sel=%0d got rv/re=%b%b exp 10", sel, dbg.RSP_VALID, dbg.RSP_ERR);
      end
      issue(3'd3, {2'b00, sel}, 8'h00);
      repeat (3) @(negedge clk);  // E2
      checks++;
      if (dvec() !== rd_d) begin
        failures++;
        $display("FAIL rr_step sel=%0d got d=%h exp %h", sel, dvec(), rd_d);
      end
      @(negedge clk);  // E3
      checks++;
      if (dbg.RDATA !== val) begin
        failures++;
        $display("FAIL rr_rdata sel=%0d got %h exp %h", sel, dbg.RDATA, val);
      end
      repeat (2) @(negedge clk);  // E5
      checks++;
      if ({dbg.RSP_VALID, dbg.RSP_ERR} !== 2'b10) begin
        failures++;
        $display("FAIL rr_rsp sel=%0d got rv/re=%b%b exp 10", sel, dbg.RSP_VALID, dbg.RSP_ERR);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int n   = 0;
    bit got = 1'b0;
    ack_en = 1'b0;
    issue(3'd1, 4'h7, 8'h99);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dbg.DEBUG_REQUEST) n++;
      if (dbg.RSP_VALID) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || n != 64 || dbg.RSP_ERR !== 1'b1 || dbg.RDATA !== 8'h42 || dvec() !== IDLE_D) begin
      failures++;
      $display("FAIL timeout got rsp=%b req_cycles=%0d re=%b rdata=%h d=%h exp 1 64 1 42 %h",
               got, n, dbg.RSP_ERR, dbg.RDATA, dvec(), IDLE_D);
    end
    ack_en = 1'b1;
    @(negedge clk);
    checks++;
    if ({dbg.CMD_READY, dbg.RSP_VALID, dbg.DEBUG_REQUEST} !== 3'b100) begin
      failures++;
      $display("FAIL timeout_after got rdy/rv/req=%b%b%b exp 100", dbg.CMD_READY, dbg.RSP_VALID, dbg.DEBUG_REQUEST);
    end
  endtask

  task automatic test_reserved_busy();
    bit got = 1'b0;
    issue(3'd6, 4'h0, 8'h00);
    @(negedge clk);  // E0
    checks++;
    if ({dbg.RSP_VALID, dbg.RSP_ERR, dbg.DEBUG_REQUEST, dbg.CMD_READY} !== 4'b1100) begin
      failures++;
      $display("FAIL reserved got rv/re/req/rdy=%b%b%b%b exp 1100", dbg.RSP_VALID, dbg.RSP_ERR, dbg.DEBUG_REQUEST, dbg.CMD_READY);
    end
    @(negedge clk);
    dbg.CMD_VALID = 1'b1;
    dbg.CMD_OP    = 3'd1;
    dbg.CMD_ADDR  = 4'h2;
    dbg.CMD_DATA  = 8'h55;
    @(posedge clk);  // E0 of the write
    #1;
    dbg.CMD_OP    = 3'd5;
    dbg.CMD_ADDR  = 4'h0;
    dbg.CMD_DATA  = 8'h00;
    repeat (3) @(negedge clk);  // E2
    checks++;
    if (dvec() !== MA_STEP || dbg.DEBUG_DATA !== 8'h02) begin
      failures++;
      $display("FAIL busy_step1 got d=%h dd=%h exp d=%h dd=02", dvec(), dbg.DEBUG_DATA, MA_STEP);
    end
    @(negedge clk);  // E3
    checks++;
    if (dbg.DEBUG_DATA !== 8'h55) begin
      failures++;
      $display("FAIL busy_step2 got dd=%h exp 55", dbg.DEBUG_DATA);
    end
    repeat (3) @(negedge clk);  // E6
    checks++;
    if ({dbg.RSP_VALID, dbg.RSP_ERR, dbg.CMD_READY} !== 3'b100) begin
      failures++;
      $display("FAIL busy_rsp got rv/re/rdy=%b%b%b exp 100", dbg.RSP_VALID, dbg.RSP_ERR, dbg.CMD_READY);
    end
    @(negedge clk);  // E7
    checks++;
    if ({dbg.CMD_READY, dbg.DEBUG_REQUEST} !== 2'b10) begin
      failures++;
      $display("FAIL busy_ready got rdy/req=%b%b exp 10", dbg.CMD_READY, dbg.DEBUG_REQUEST);
    end
    @(negedge clk);  // E8: held command accepted
    checks++;
    if ({dbg.CMD_READY, dbg.DEBUG_REQUEST} !== 2'b01) begin
      failures++;
      $display("FAIL busy_accept got rdy/req=%b%b exp 01", dbg.CMD_READY, dbg.DEBUG_REQUEST);
    end
    dbg.CMD_VALID = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dvec() !== (IDLE_D | M_CLR)) begin
      failures++;
      $display("FAIL clear_step got d=%h exp %h", dvec(), IDLE_D | M_CLR);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg.RSP_VALID) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || dbg.RSP_ERR !== 1'b0 || ram[2] !== 8'h55) begin
      failures++;
      $display("FAIL clear_rsp got rsp=%b re=%b ram2=%h exp 1 0 55", got, dbg.RSP_ERR, ram[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rsp_seen = 0;
    int req_seen = 0;
    issue(3'd1, 4'h9, 8'h77);
    repeat (3) @(negedge clk);  // E2: STEP1
    checks++;
    if (dvec() !== MA_STEP) begin
      failures++;
      $display("FAIL rst_mid_pre got d=%h exp %h", dvec(), MA_STEP);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({dbg.DEBUG_REQUEST, dbg.CMD_READY, dbg.RSP_VALID} !== 3'b010 || dvec() !== IDLE_D || dbg.RDATA !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid got req/rdy/rv=%b%b%b d=%h rdata=%h exp 010 %h 00",
               dbg.DEBUG_REQUEST, dbg.CMD_READY, dbg.RSP_VALID, dvec(), IDLE_D, dbg.RDATA);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dbg.RSP_VALID) rsp_seen++;
      if (dbg.DEBUG_REQUEST) req_seen++;
    end
    checks++;
    if (rsp_seen != 0 || req_seen != 0 || ram[9] === 8'h77) begin
      failures++;
      $display("FAIL rst_mid_after got rsp=%0d req=%0d ram9=%h exp 0 0 not-77", rsp_seen, req_seen, ram[9]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    ack_en        = 1'b1;
    dbg.CMD_VALID = 1'b0;
    dbg.CMD_OP    = 3'd0;
    dbg.CMD_ADDR  = 4'h0;
    dbg.CMD_DATA  = 8'h00;
    test_reset();
    test_mem_write();
    test_mem_read();
    test_reg_access();
    test_timeout();
    test_reserved_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/be8_debug_host.md
# be8_debug_host

Debug-port initiator for the 8-bit `core`: it drives `DEBUG_REQUEST`, `DEBUG_DATA` and the `D_*` control overrides, and waits on `DEBUG_ACK`. Each accepted host command becomes a halt / step / release transaction that writes or reads RAM or registers over `BUS`. It sits between a pin-level command source and the core's debug inputs, which are currently tied off in the top level.

## Interface
Parameters:
- `ADDR_W`, 4: RAM address width; the MAR is loaded from `BUS[ADDR_W-1:0]`.
- `ACK_TIMEOUT`, 64: maximum cycles spent waiting for `DEBUG_ACK` to change before the transaction aborts.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: clock; all state updates on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `CMD_VALID` in 1: a command is presented.
- `CMD_READY` out 1: high only in IDLE.
- `CMD_OP` in 3: opcode (see Operation).
- `CMD_ADDR` in `ADDR_W`: RAM address, or register select in bits [1:0].
- `CMD_DATA` in 8: write data.
- `RSP_VALID` out 1: one-cycle completion pulse.
- `RSP_ERR` out 1: qualifies `RSP_VALID`; 1 = timeout or reserved opcode.
- `RDATA` out 8: last captured read value; holds until the next read.
- `DEBUG_REQUEST` out 1: asks the core to halt and yield the bus.
- `DEBUG_ACK` in 1: core is halted and obeying the `D_*` signals.
- `DEBUG_DATA` out 8: value driven onto `BUS` while `D_DOn` = 0.
- `D_CLR`, `D_HLT`, `D_CE`, `D_SU`, `D_RI` out 1 each: active-high control overrides.
- `D_AIn`, `D_BIn`, `D_OIn`, `D_IIn`, `D_Jn`, `D_FIn`, `D_MIn`, `D_DOn`, `D_AOn`, `D_BOn`, `D_IOn`, `D_COn`, `D_EOn`, `D_ROn`, `D_NOn` out 1 each: active-low control overrides.
- `BUS` in 8: core bus, sampled on read steps.

## Operation
- FSM states: IDLE, REQ, STEP1, STEP2, REL, DONE.
- Outputs are a Moore decode of the state and the latched command. Every `D_*` signal is deasserted except in STEP1 and STEP2: active-high signals = 0, active-low signals = 1.
- Accept: `CMD_VALID` && `CMD_READY` at an edge latches OP, ADDR and DATA.
  - If the op needs the core, go to REQ.
  - Otherwise go straight to DONE.
  - `CMD_VALID` is ignored outside IDLE; nothing is buffered.
- REQ: `DEBUG_REQUEST` = 1.
  - `DEBUG_ACK` sampled 1 → STEP1.
  - Timeout counter reaches `ACK_TIMEOUT` → DONE with error.
- Steps: each step lasts exactly one cycle, with `DEBUG_REQUEST` held at 1. Per opcode:
  - 0 NOP: no core access; DONE, no error.
  - 1 MEM_WRITE:
    - STEP1: `DEBUG_DATA` = ADDR zero-extended, `D_DOn` = 0, `D_MIn` = 0.
    - STEP2: `DEBUG_DATA` = DATA, `D_DOn` = 0, `D_RI` = 1.
  - 2 MEM_READ:
    - STEP1: same as MEM_WRITE STEP1.
    - STEP2: `D_ROn` = 0; `RDATA` <= `BUS` at the end of STEP2.
  - 3 REG_READ, single step: `D_AOn`/`D_BOn`/`D_IOn`/`D_COn` = 0 for select 0/1/2/3; `RDATA` <= `BUS` at the end of STEP1.
  - 4 REG_WRITE, single step: `D_DOn` = 0, `DEBUG_DATA` = DATA, and `D_AIn`/`D_BIn`/`D_OIn`/`D_Jn` = 0 for select 0/1/2/3 (A, B, OUT, PC).
  - 5 CLEAR, single step: `D_CLR` = 1.
  - 6, 7 reserved: no request; DONE with `RSP_ERR` = 1.
- REL: `DEBUG_REQUEST` = 0, `D_*` idle.
  - `DEBUG_ACK` sampled 0 → DONE.
  - Timeout → DONE with error.
- DONE: `RSP_VALID` = 1 for one cycle, then IDLE.
- Timeout counter: cleared on entry to REQ and to REL; increments every cycle spent in those states. The compare is `count == ACK_TIMEOUT-1` at an edge.

## Timing
- Reset values (after any edge with `RESET` = 1):
  - State IDLE; `CMD_READY` = 1.
  - `RSP_VALID` = 0, `RSP_ERR` = 0, `RDATA` = 0x00.
  - `DEBUG_REQUEST` = 0, `DEBUG_DATA` = 0x00.
  - All `D_*` deasserted.
- Reset mid-transaction: the next edge forces IDLE, drops `DEBUG_REQUEST` and produces no response; `RDATA` is cleared.
- Latency, accept edge = E0, responder acknowledging one cycle after it samples a change:
  - 2-step ops: STEP1 in [E2,E3), STEP2 in [E3,E4), REL from E4, DONE in [E6,E7), `CMD_READY` again from E7.
  - 1-step ops: `RSP_VALID` in [E5,E6).
  - NOP / reserved: `RSP_VALID` in [E0,E1).
- `DEBUG_ACK` already 1 in the first REQ cycle: STEP1 starts at E1.
- `RSP_ERR` is valid only while `RSP_VALID` = 1 and reads 0 otherwise.

## Test plan
- MEM_WRITE addr 0x5, data 0xA7, responder model with 1-cycle ack → STEP1 shows `DEBUG_DATA` = 0x05 with `D_MIn`, `D_DOn` low; STEP2 shows 0xA7 with `D_RI` = 1; `RSP_VALID` at E6 with `RSP_ERR` = 0; model RAM[5] = 0xA7.
- MEM_READ addr 0x5 after the write, model drives RAM onto `BUS` when `D_ROn` = 0 → `RDATA` = 0xA7 at E4; `RSP_VALID` at E6.
- REG_WRITE sel 0 data 0x3C, then REG_READ sel 0 → `D_AIn` low one cycle, then `D_AOn` low one cycle; `RDATA` = 0x3C; each response at E5.
- Responder never acks → `DEBUG_REQUEST` high for exactly 64 cycles, then low; `RSP_VALID` with `RSP_ERR` = 1; `RDATA` unchanged.
- Reserved op 6, and `CMD_VALID` held high while busy → error response at E0 with no `DEBUG_REQUEST`; the busy-time command is not accepted until `CMD_READY` returns.
- `RESET` asserted during STEP1 of a MEM_WRITE → `DEBUG_REQUEST` and all `D_*` idle at the next edge; no `RSP_VALID`; `CMD_READY` = 1.
